// File: rtl/tone_sequencer_if.sv
// -----------------------------------------------------------------------------
// tone_sequencer_if
// Bus between the tone sequencer and its external synchronous score ROM.
//   rom_addr : score entry address, driven by the sequencer (registered)
//   rom_data : score entry for rom_addr, returned one clock after the address
//
// Modports:
//   master : sequencer side (drives rom_addr, reads rom_data)
//   slave  : ROM side (reads rom_addr, drives rom_data)
// -----------------------------------------------------------------------------
interface tone_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 46
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
// Score player for the PMOD speaker outputs. Entries are read from an external
// synchronous ROM. Each entry holds a tone half-period, a duration and a stereo
// pan. An entry with dur==0 marks the end of the score, and an entry with
// half==0 is a rest. Every note ends with GAP silent clocks of articulation.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      begin playback from entry 0 (only honoured while idle)
//   stop       abort playback (wins over every other transition)
//   loop_en    restart at entry 0 at the end of the score
//   rom        score ROM bus (master side): rom_addr out, rom_data in
//   busy       high whenever not idle
//   done       one-clock pulse on a natural end of the score
//   speaker_l  left square-wave output (registered)
//   speaker_r  right square-wave output (registered)
// -----------------------------------------------------------------------------
module tone_sequencer #(
    parameter int DIV_W  = 17,
    parameter int DUR_W  = 27,
    parameter int ADDR_W = 5,
    parameter int GAP    = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    tone_sequencer_if.master rom,
    output logic             busy,
    output logic             done,
    output logic             speaker_l,
    output logic             speaker_r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_PLAY
    } state_t;

    localparam logic [DUR_W-1:0] GAP_V = DUR_W'(GAP);

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                r_done;
    logic                w_done_set;
    logic                w_latch_note;

    logic [DIV_W-1:0]    r_half;
    logic [DUR_W-1:0]    r_dur;
    logic [1:0]          r_pan;
    logic                r_tone;
    logic [DIV_W-1:0]    r_tone_cnt;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic                r_spk_l;
    logic                r_spk_r;

    logic [DIV_W-1:0]    w_half;
    logic [DUR_W-1:0]    w_dur;
    logic [1:0]          w_pan;
    logic                w_note_end;
    logic                w_last_addr;
    logic                w_body;
    logic                w_playing;

    // Entry fields, meaningful in LOAD (one clock after rom_addr settled).
    assign w_half = rom.rom_data[DIV_W+DUR_W+1:DUR_W+2];
    assign w_dur  = rom.rom_data[DUR_W+1:2];
    assign w_pan  = rom.rom_data[1:0];

    assign w_note_end  = (r_dur_cnt == r_dur - DUR_W'(1));
    assign w_last_addr = (r_addr == {ADDR_W{1'b1}});
    assign w_playing   = (r_state == S_PLAY);

    // Audible part of the note: everything except the trailing GAP clocks.
    // A note no longer than GAP never becomes audible.
    assign w_body = (r_dur > GAP_V) && (r_dur_cnt < (r_dur - GAP_V));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // the values present before the edge, regardless of block order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is defaulted first; a path that
        // skipped an assignment would otherwise infer a latch.
        w_next_state = r_state;
        w_next_addr  = r_addr;
        w_done_set   = 1'b0;
        w_latch_note = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_next_addr  = '0;
                    w_next_state = S_WAIT;
                end
            end

            S_WAIT: begin
                w_next_state = stop ? S_IDLE : S_LOAD;
            end

            S_LOAD: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                end else if (w_dur == '0) begin
                    // A marker at entry 0 always ends playback, so an empty
                    // score cannot spin forever with loop_en set.
                    if (loop_en && (r_addr != '0)) begin
                        w_next_addr  = '0;
                        w_next_state = S_WAIT;
                    end else begin
                        w_done_set   = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_latch_note = 1'b1;
                    w_next_state = S_PLAY;
                end
            end

            S_PLAY: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                end else if (w_note_end) begin
                    // Address always advances; leaving the last entry wraps to
                    // 0 and counts as the end of the score.
                    w_next_addr = r_addr + 1'b1;
                    if (w_last_addr && !loop_en) begin
                        w_done_set   = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address, note registers, tone generator, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_done     <= 1'b0;
            r_half     <= '0;
            r_dur      <= '0;
            r_pan      <= '0;
            r_tone     <= 1'b0;
            r_tone_cnt <= '0;
            r_dur_cnt  <= '0;
            r_spk_l    <= 1'b0;
            r_spk_r    <= 1'b0;
        end else begin
            r_addr  <= w_next_addr;
            r_done  <= w_done_set;
            r_spk_l <= r_tone & r_pan[1] & w_body & w_playing;
            r_spk_r <= r_tone & r_pan[0] & w_body & w_playing;

            if (w_latch_note) begin
                r_half     <= w_half;
                r_dur      <= w_dur;
                r_pan      <= w_pan;
                r_tone     <= 1'b0;
                r_tone_cnt <= w_half - DIV_W'(1);
                r_dur_cnt  <= '0;
            end else if (w_playing && !stop) begin
                r_dur_cnt <= r_dur_cnt + DUR_W'(1);
                if (w_note_end) begin
                    r_tone <= 1'b0;
                end else if (r_half != '0) begin
                    // Toggle every half clocks: first toggle lands half clocks
                    // after PLAY entry because LOAD preloads half-1.
                    if (r_tone_cnt == '0) begin
                        r_tone     <= ~r_tone;
                        r_tone_cnt <= r_half - DIV_W'(1);
                    end else begin
                        r_tone_cnt <= r_tone_cnt - DIV_W'(1);
                    end
                end
            end
        end
    end

    assign rom.rom_addr = r_addr;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign speaker_l    = r_spk_l;
    assign speaker_r    = r_spk_r;

endmodule
